// File: rtl/lorentz_run_ctrl.sv
// lorentz_run_ctrl
//   Run sequencer for the lorentz Euler-step integrator. A start request loads
//   the integrator's initial state, then issues num_steps integration steps.
//   Every decim-th state (and always the final one) is captured into a single
//   valid/ready output slot. The integrator is stalled rather than letting a
//   captured sample be overwritten before it is accepted.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   start, abort        run request (IDLE only) / cancel back to IDLE
//   num_steps, decim    run length and decimation, latched on start
//   busy, done          not-IDLE flag, 1-cycle normal completion pulse
//   int_init, int_en    integrator load / advance strobes
//   int_x/y/z           integrator state, valid the cycle after int_en
//   out_valid/out_ready sample slot handshake
//   out_x/y/z, out_idx  captured sample and its 1-based step number
//   dbg_state           current FSM state, for observation only
//
// Handshake: a sample transfers on every rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and the sample is not accepted,
// out_x/y/z and out_idx hold their values. out_valid does not depend
// combinationally on out_ready.

module lorentz_run_ctrl #(
  parameter int W     = 64,
  parameter int CNT_W = 32,
  parameter int DEC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [DEC_W-1:0] decim,
  output logic             busy,
  output logic             done,
  output logic             int_init,
  output logic             int_en,
  input  logic [W-1:0]     int_x,
  input  logic [W-1:0]     int_y,
  input  logic [W-1:0]     int_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_x,
  output logic [W-1:0]     out_y,
  output logic [W-1:0]     out_z,
  output logic [CNT_W-1:0] out_idx,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_num_steps;
  logic [DEC_W-1:0] r_decim;
  logic [CNT_W-1:0] r_step_cnt;
  logic [DEC_W-1:0] r_dec_cnt;
  logic             r_cap_pend;
  logic             r_out_valid;
  logic [W-1:0]     r_out_x;
  logic [W-1:0]     r_out_y;
  logic [W-1:0]     r_out_z;
  logic [CNT_W-1:0] r_out_idx;

  logic [CNT_W:0]   w_step_inc;
  logic [DEC_W:0]   w_dec_inc;
  logic             w_last;
  logic             w_sample;
  logic             w_slot_ok;
  logic             w_accept;
  logic             w_issue;
  logic             w_busy;
  logic             w_done;
  logic             w_int_init;

  // One extra bit so the compare is exact even at num_steps = 2^CNT_W-1.
  assign w_step_inc = {1'b0, r_step_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_dec_inc  = {1'b0, r_dec_cnt} + {{DEC_W{1'b0}}, 1'b1};
  assign w_last     = (w_step_inc == {1'b0, r_num_steps});
  assign w_sample   = (w_dec_inc == {1'b0, r_decim}) || w_last;
  // A sample step may only be issued if its capture, one edge later, lands in
  // a slot that is empty or being emptied now.
  assign w_slot_ok  = !r_cap_pend && (!r_out_valid || out_ready);
  assign w_accept   = r_out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = (r_state != S_IDLE);
    w_done      = 1'b0;
    w_int_init  = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (num_steps == '0) ? S_FIN : S_INIT;
        end
      end
      S_INIT: begin
        w_int_init  = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!w_sample || w_slot_ok) begin
          w_issue = 1'b1;
          if (w_last) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Final capture must have landed and been handed off.
        if (!r_cap_pend && (!r_out_valid || out_ready)) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Abort overrides everything, including a same-cycle start.
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_done      = 1'b0;
      w_int_init  = 1'b0;
      w_issue     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_num_steps <= '0;
      r_decim     <= '0;
      r_step_cnt  <= '0;
      r_dec_cnt   <= '0;
      r_cap_pend  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start && !abort) begin
        r_num_steps <= num_steps;
        r_decim     <= (decim == '0) ? {{(DEC_W-1){1'b0}}, 1'b1} : decim;
      end
      if (r_state == S_INIT) begin
        r_step_cnt <= '0;
        r_dec_cnt  <= '0;
      end else if (w_issue) begin
        r_step_cnt <= w_step_inc[CNT_W-1:0];
        r_dec_cnt  <= w_sample ? '0 : w_dec_inc[DEC_W-1:0];
      end
      // The integrator output is valid exactly one cycle after int_en, so the
      // pending flag lives for one cycle and then the capture happens.
      r_cap_pend <= w_issue && w_sample;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_z     <= '0;
      r_out_idx   <= '0;
    end else if (abort) begin
      r_out_valid <= 1'b0;
    end else if (r_cap_pend) begin
      // step_cnt was bumped when the step issued, so it already holds the
      // 1-based number of the step being captured.
      r_out_valid <= 1'b1;
      r_out_x     <= int_x;
      r_out_y     <= int_y;
      r_out_z     <= int_z;
      r_out_idx   <= r_step_cnt;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end
  end

  assign busy      = w_busy;
  assign done      = w_done;
  assign int_init  = w_int_init;
  assign int_en    = w_issue;
  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign out_y     = r_out_y;
  assign out_z     = r_out_z;
  assign out_idx   = r_out_idx;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lorentz_run_ctrl.sv
module tb_lorentz_run_ctrl;
  localparam int W     = 64;
  localparam int CNT_W = 32;
  localparam int DEC_W = 8;
  localparam logic [W-1:0] X0 = 64'h1000_0000_0000_0000;
  localparam logic [W-1:0] Y0 = 64'h0000_0000_0000_2000;
  localparam logic [W-1:0] Z0 = 64'hFFFF_FFFF_FFFF_FFF0;

  // ---------------- clock / reset / signals ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] num_steps = '0;
  logic [DEC_W-1:0] decim = '0;
  logic             busy, done, int_init, int_en;
  logic [W-1:0]     int_x = '0, int_y = '0, int_z = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [W-1:0]     out_x, out_y, out_z;
  logic [CNT_W-1:0] out_idx;
  logic [2:0]       dbg_state;

  always #5 clk = ~clk;

  lorentz_run_ctrl #(.W(W), .CNT_W(CNT_W), .DEC_W(DEC_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_steps(num_steps), .decim(decim),
    .busy(busy), .done(done), .int_init(int_init), .int_en(int_en),
    .int_x(int_x), .int_y(int_y), .int_z(int_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_idx(out_idx),
    .dbg_state(dbg_state)
  );

  // Stand-in integrator: after step n the state is (X0+n, Y0+2n, Z0+3n).
  always @(posedge clk) begin
    if (int_init) begin
      int_x <= X0;
      int_y <= Y0;
      int_z <= Z0;
    end else if (int_en) begin
      int_x <= int_x + W'(1);
      int_y <= int_y + W'(2);
      int_z <= int_z + W'(3);
    end
  end

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_q[$];
  int           en_cnt = 0, init_cnt = 0, done_cnt = 0;
  logic         hold_v = 1'b0;
  logic [CNT_W-1:0] hold_idx = '0;
  logic [W-1:0] hold_x = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected step index per accepted sample.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset) begin
      hold_v = 1'b0;
    end else begin
      if (int_en)   en_cnt++;
      if (int_init) init_cnt++;
      if (done)     done_cnt++;
      if (hold_v && out_valid) begin
        check("hold_idx_stable", W'(out_idx), W'(hold_idx));
        check("hold_x_stable", out_x, hold_x);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_sample actual_idx=%0d required=none", out_idx);
        end else begin
          e = exp_q.pop_front();
          check("sample_idx", W'(out_idx), e);
          check("sample_x", out_x, X0 + e);
          check("sample_y", out_y, Y0 + W'(2) * e);
          check("sample_z", out_z, Z0 + W'(3) * e);
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_idx = out_idx;
      hold_x   = out_x;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_cnts();
    en_cnt = 0;
    init_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic push_seq(input int first, input int step, input int last);
    for (int i = first; i <= last; i += step) exp_q.push_back(W'(i));
  endtask

  // Start pulse is sampled at the second posedge here; inputs are then
  // scrambled to show mid-run changes are ignored.
  task automatic start_run(input logic [CNT_W-1:0] n, input logic [DEC_W-1:0] d);
    @(posedge clk); #1;
    num_steps = n;
    decim = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    num_steps = CNT_W'($urandom_range(1, 5));
    decim = DEC_W'($urandom_range(0, 3));
  endtask

  task automatic wait_done(input string name, input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat < 0) begin
      failures++;
      $display("FAIL %s_done_timeout actual=none required=done within %0d cycles", name, budget);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    int k;
    logic found;

    // Reset state, sampled while reset is still asserted.
    #12;
    check("rst_busy", W'(busy), 64'd0);
    check("rst_done", W'(done), 64'd0);
    check("rst_int_init", W'(int_init), 64'd0);
    check("rst_int_en", W'(int_en), 64'd0);
    check("rst_out_valid", W'(out_valid), 64'd0);
    check("rst_out_x", out_x, 64'd0);
    check("rst_out_idx", W'(out_idx), 64'd0);
    check("rst_state", W'(dbg_state), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // T2: 10 steps, every step sampled, sink always ready.
    clear_cnts();
    push_seq(1, 1, 10);
    start_run(32'd10, 8'd1);
    wait_done("t2", 80, lat);
    check("t2_latency", W'(lat), 64'd23);
    check("t2_int_en", W'(en_cnt), 64'd10);
    check("t2_int_init", W'(init_cnt), 64'd1);
    check("t2_done", W'(done_cnt), 64'd1);
    check("t2_q_empty", W'(exp_q.size()), 64'd0);
    check("t2_idle", W'(busy), 64'd0);

    // T3: decimation 4 -> 4, 8 and final 10.
    clear_cnts();
    exp_q.push_back(64'd4);
    exp_q.push_back(64'd8);
    exp_q.push_back(64'd10);
    start_run(32'd10, 8'd4);
    wait_done("t3", 80, lat);
    check("t3_int_en", W'(en_cnt), 64'd10);
    check("t3_done", W'(done_cnt), 64'd1);
    check("t3_q_empty", W'(exp_q.size()), 64'd0);

    // T4: sink stalls right after the first sample (idx 2).
    clear_cnts();
    out_ready = 1'b0;
    push_seq(2, 2, 8);
    start_run(32'd8, 8'd2);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_first_valid", W'(found), 64'd1);
    repeat (19) begin
      @(posedge clk); #1;
    end
    check("t4_stall_int_en", W'(en_cnt), 64'd3);
    check("t4_stall_int_en_low", W'(int_en), 64'd0);
    check("t4_held_valid", W'(out_valid), 64'd1);
    check("t4_held_idx", W'(out_idx), 64'd2);
    out_ready = 1'b1;
    wait_done("t4", 80, lat);
    check("t4_int_en", W'(en_cnt), 64'd8);
    check("t4_done", W'(done_cnt), 64'd1);
    check("t4_q_empty", W'(exp_q.size()), 64'd0);

    // T5: abort while step 5 of 10 is in flight.
    clear_cnts();
    push_seq(1, 1, 4);
    start_run(32'd10, 8'd1);
    k = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (int_en) k++;
      if (k == 5) break;
    end
    check("t5_reach_step5", W'(k), 64'd5);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t5_abort_busy", W'(busy), 64'd0);
    check("t5_abort_valid", W'(out_valid), 64'd0);
    check("t5_abort_state", W'(dbg_state), 64'd0);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("t5_no_done", W'(done_cnt), 64'd0);
    check("t5_int_en", W'(en_cnt), 64'd5);
    check("t5_q_empty", W'(exp_q.size()), 64'd0);
    clear_cnts();
    push_seq(1, 1, 3);
    start_run(32'd3, 8'd1);
    wait_done("t5_rerun", 40, lat);
    check("t5_rerun_done", W'(done_cnt), 64'd1);
    check("t5_rerun_int_en", W'(en_cnt), 64'd3);
    check("t5_rerun_q_empty", W'(exp_q.size()), 64'd0);

    // T6: zero-length run, then decim=0 with a start issued while busy.
    clear_cnts();
    start_run(32'd0, 8'd5);
    wait_done("t6_zero", 10, lat);
    check("t6_zero_latency_ok", W'(lat >= 1 && lat <= 2), 64'd1);
    check("t6_zero_int_en", W'(en_cnt), 64'd0);
    check("t6_zero_int_init", W'(init_cnt), 64'd0);
    check("t6_zero_done", W'(done_cnt), 64'd1);
    clear_cnts();
    push_seq(1, 1, 4);
    start_run(32'd4, 8'd0);
    @(posedge clk); #1;
    start = 1'b1;
    num_steps = 32'd2;
    decim = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6_busy", 60, lat);
    check("t6_busy_int_init", W'(init_cnt), 64'd1);
    check("t6_busy_int_en", W'(en_cnt), 64'd4);
    check("t6_busy_done", W'(done_cnt), 64'd1);
    check("t6_busy_q_empty", W'(exp_q.size()), 64'd0);

    // T1: asynchronous reset in the middle of a stalled run.
    clear_cnts();
    out_ready = 1'b0;
    start_run(32'd10, 8'd1);
    repeat (6) @(posedge clk);
    #2;
    check("t1_pre_busy", W'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("t1_busy", W'(busy), 64'd0);
    check("t1_int_en", W'(int_en), 64'd0);
    check("t1_out_valid", W'(out_valid), 64'd0);
    check("t1_out_idx", W'(out_idx), 64'd0);
    check("t1_out_x", out_x, 64'd0);
    check("t1_state", W'(dbg_state), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    clear_cnts();
    push_seq(1, 1, 2);
    start_run(32'd2, 8'd1);
    wait_done("t1_rerun", 40, lat);
    check("t1_rerun_done", W'(done_cnt), 64'd1);
    check("t1_rerun_q_empty", W'(exp_q.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
